// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 128x128->512 MAC datapath: clears the accumulator, streams
// operand pairs into it, waits for the pipeline to drain and returns the result.
module mac_seq_ctrl #(
  parameter int A_W     = 128,
  parameter int ACC_W   = 512,
  parameter int LEN_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [A_W-1:0]   op_a,
  input  logic [A_W-1:0]   op_b,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [A_W-1:0]   mac_a,
  output logic [A_W-1:0]   mac_b,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [LEN_W-1:0] res_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int             DW         = $clog2(MAC_LAT + 3);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(MAC_LAT + 1);
  localparam logic [DW-1:0]  DRAIN_ONE  = DW'(1);

  state_t             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [DW-1:0]      drain_q;
  logic               mac_clr_q;
  logic               mac_en_q;
  logic [A_W-1:0]     mac_a_q;
  logic [A_W-1:0]     mac_b_q;
  logic               res_valid_q;
  logic [ACC_W-1:0]   res_data_q;
  logic [LEN_W-1:0]   res_count_q;

  logic xfer;

  assign op_ready  = (state_q == S_STREAM);
  assign busy      = (state_q != S_IDLE);
  assign xfer      = op_valid & op_ready;

  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_count = res_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q     <= len;
            cnt_q     <= '0;
            drain_q   <= '0;
            mac_clr_q <= 1'b1;
            state_q   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // Drain counts MAC_LAT+1 cycles after the last MAC-visible event: the
          // final mac_en cycle when streaming, or the clear cycle for an empty job.
          if (len_q != '0) begin
            state_q <= S_STREAM;
          end else begin
            drain_q <= DRAIN_ONE;
            state_q <= S_DRAIN;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            mac_en_q <= 1'b1;
            mac_a_q  <= op_a;
            mac_b_q  <= op_b;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              drain_q <= '0;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            res_data_q  <= mac_acc;
            res_count_q <= len_q;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
